// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the 7-segment scan driver:
//   SEG_BLANK  - all segments off (active-low pattern)
//   GLYPH_LUT  - hex glyphs 0..F, active-low, bit6 = segment a ... bit0 = g
//   f_idx_w    - counter/index width helper
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] GLYPH_LUT [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    function automatic int f_idx_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
// Bus-side control of the scan driver, written by the peripheral logic.
//   en_i       scan enable (0 = display dark, scan frozen)
//   we_i       one-cycle write strobe for data_i/dp_i
//   data_i     4*N_DIGITS hex value, digit 0 in the low nibble
//   dp_i       decimal point per digit, 1 = lit
//   lz_supp_i  1 = blank leading zeros
// master: peripheral logic driving the display; slave: the scan driver.
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if #(
    parameter int N_DIGITS = 8
);
    logic                    en_i;
    logic                    we_i;
    logic [4*N_DIGITS-1:0]   data_i;
    logic [N_DIGITS-1:0]     dp_i;
    logic                    lz_supp_i;

    modport master (output en_i, output we_i, output data_i, output dp_i, output lz_supp_i);
    modport slave  (input  en_i, input  we_i, input  data_i, input  dp_i, input  lz_supp_i);
endinterface

// File: rtl/seg7_glyph_dec.sv
// -----------------------------------------------------------------------------
// seg7_glyph_dec
// Combinational hex nibble to active-low 7-segment glyph.
//   nib_i  in  4   hex digit
//   seg_o  out 7   {a,b,c,d,e,f,g}, active-low; blank for an unknown input
// -----------------------------------------------------------------------------
module seg7_glyph_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // An X/Z nibble never compares equal to a constant, so it falls through
    // to the blank pattern instead of propagating X onto the pins.
    always_comb begin
        seg_o = SEG_BLANK;
        for (int k = 0; k < 16; k++) begin
            if (nib_i == 4'(k)) begin
                seg_o = GLYPH_LUT[k];
            end
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// One digit is lit per refresh slot; the first BLANK_CYC cycles of every slot
// keep all anodes off to avoid ghosting. Writes land in a shadow register and
// are copied to the display register only when the scan wraps to digit 0, so
// a frame never mixes old and new values.
// Ports:
//   clk_i     in   1          clock
//   rst_n_i   in   1          synchronous active-low reset
//   bus       slave           en/we/data/dp/lz_supp control (seg7_scan_driver_if)
//   seg_o     out  7          segments {a..g}, active-low
//   dp_o      out  1          decimal point, active-low
//   an_o      out  N_DIGITS   anodes, active-low, at most one low
//   frame_o   out  1          one-cycle pulse when a new frame starts
// -----------------------------------------------------------------------------
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 8,
    parameter int REFRESH_DIV = 10000,
    parameter int BLANK_CYC   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    seg7_scan_driver_if.slave     bus,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [N_DIGITS-1:0]   an_o,
    output logic                  frame_o
);

    localparam int CNT_W = f_idx_w(REFRESH_DIV);
    localparam int IDX_W = f_idx_w(N_DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

    // Scan state
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    // Shadow (bus side) and display (scan side) copies of the value
    logic [4*N_DIGITS-1:0]   shadow_data_q, shadow_data_d;
    logic [N_DIGITS-1:0]     shadow_dp_q,   shadow_dp_d;
    logic [4*N_DIGITS-1:0]   disp_data_q,   disp_data_d;
    logic [N_DIGITS-1:0]     disp_dp_q,     disp_dp_d;

    // Output registers
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q,  dp_d;
    logic [N_DIGITS-1:0]     an_q,  an_d;
    logic                    frame_q, frame_d;

    logic                    slot_end;
    logic                    wrap;
    logic [N_DIGITS-1:0]     supp;
    logic                    zero_run;
    logic [3:0]              cur_nib;
    logic [6:0]              glyph;

    // Slot counter and digit index; both freeze while the scan is disabled.
    always_comb begin
        slot_end = bus.en_i && (cnt_q == CNT_LAST);
        wrap     = slot_end && (idx_q == IDX_LAST);
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        if (bus.en_i) begin
            if (slot_end) begin
                cnt_d = '0;
                idx_d = wrap ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Writes are accepted regardless of en_i. The display copy takes the shadow
    // value as it was before this edge, so a write on the wrap cycle waits one
    // more frame rather than tearing the frame that is just starting.
    always_comb begin
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        disp_data_d   = disp_data_q;
        disp_dp_d     = disp_dp_q;
        if (bus.we_i) begin
            shadow_data_d = bus.data_i;
            shadow_dp_d   = bus.dp_i;
        end
        if (wrap) begin
            disp_data_d = shadow_data_q;
            disp_dp_d   = shadow_dp_q;
        end
    end

    // Leading-zero mask: walk from the most significant digit down while every
    // nibble seen so far is zero. Digit 0 is never suppressed.
    always_comb begin
        zero_run = 1'b1;
        supp     = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (disp_data_q[4*k +: 4] == 4'h0);
            supp[k]  = bus.lz_supp_i && zero_run && (k != 0);
        end
    end

    assign cur_nib = disp_data_q[{idx_q, 2'b00} +: 4];

    seg7_glyph_dec u_glyph_dec (
        .nib_i (cur_nib),
        .seg_o (glyph)
    );

    // Output decode from the current cnt/idx; registered below, so the pins
    // follow the scan state with one cycle of latency.
    always_comb begin
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        an_d    = '1;
        frame_d = wrap;
        if (bus.en_i && (cnt_q >= BLANK_END)) begin
            an_d[idx_q] = 1'b0;
            seg_d       = supp[idx_q] ? SEG_BLANK : glyph;
            dp_d        = ~disp_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            disp_data_q   <= '0;
            disp_dp_q     <= '0;
            seg_q         <= SEG_BLANK;
            dp_q          <= 1'b1;
            an_q          <= '1;
            frame_q       <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            disp_data_q   <= disp_data_d;
            disp_dp_q     <= disp_dp_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            an_q          <= an_d;
            frame_q       <= frame_d;
        end
    end

    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign an_o    = an_q;
    assign frame_o = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with N_DIGITS=4, REFRESH_DIV=20,
// BLANK_CYC=4. Expected digit slots are pushed to a queue as stimulus is
// applied and popped as the display lights each anode.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int N   = 4;
    localparam int DIV = 20;
    localparam int BLK = 4;
    localparam int LOW_LEN = DIV - BLK;

    localparam logic [6:0] TB_GLYPH [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } slot_t;

    logic         clk;
    logic         rst_n;
    logic [6:0]   seg_o;
    logic         dp_o;
    logic [N-1:0] an_o;
    logic         frame_o;

    int errors = 0;
    int checks = 0;
    slot_t sb[$];

    seg7_scan_driver_if #(.N_DIGITS(N)) bus ();

    seg7_scan_driver #(
        .N_DIGITS    (N),
        .REFRESH_DIV (DIV),
        .BLANK_CYC   (BLK)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus),
        .seg_o   (seg_o),
        .dp_o    (dp_o),
        .an_o    (an_o),
        .frame_o (frame_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference expectation for digit k of value d.
    function automatic void push_slot(input int k, input logic [15:0] d,
                                      input logic [3:0] p, input logic lz);
        slot_t      e;
        logic [3:0] nib;
        logic       blank;
        nib   = d[4*k +: 4];
        blank = lz && (k != 0) && ((d >> (4*k)) == 16'h0);
        e.an  = ~(4'b0001 << k);
        e.seg = blank ? 7'h7F : TB_GLYPH[nib];
        e.dp  = ~p[k];
        sb.push_back(e);
    endfunction

    function automatic void push_frame(input logic [15:0] d, input logic [3:0] p, input logic lz);
        for (int k = 0; k < N; k++) push_slot(k, d, p, lz);
    endfunction

    task automatic wr(input logic [15:0] d, input logic [3:0] p);
        bus.data_i = d;
        bus.dp_i   = p;
        bus.we_i   = 1'b1;
        tick();
        bus.we_i   = 1'b0;
    endtask

    task automatic wait_frame(input string tag);
        int n;
        n = 0;
        tick();
        while (frame_o !== 1'b1 && n < 400) begin tick(); n++; end
        chk({tag, " frame seen"}, 32'(frame_o), 32'd1);
    endtask

    // Wait for the next lit slot, compare it against the scoreboard head and
    // measure how long the anode stays low.
    task automatic check_slot(input string tag);
        int         n;
        slot_t      e;
        logic [3:0] an_seen;
        n = 0;
        while (an_o !== 4'hF && n < 200) begin tick(); n++; end
        n = 0;
        while (an_o === 4'hF && n < 200) begin tick(); n++; end
        chk({tag, " sb size"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " an"},  32'(an_o),  32'(e.an));
            chk({tag, " seg"}, 32'(seg_o), 32'(e.seg));
            chk({tag, " dp"},  32'(dp_o),  32'(e.dp));
        end
        an_seen = an_o;
        n = 0;
        while (an_o === an_seen && n < 200) begin n++; tick(); end
        chk({tag, " low len"}, 32'(n), 32'(LOW_LEN));
    endtask

    task automatic reset_check(input string tag);
        int n;
        slot_t e;
        rst_n = 1'b0;
        repeat (3) tick();
        chk({tag, " an"},    32'(an_o),    32'hF);
        chk({tag, " seg"},   32'(seg_o),   32'h7F);
        chk({tag, " dp"},    32'(dp_o),    32'd1);
        chk({tag, " frame"}, 32'(frame_o), 32'd0);
        sb.delete();
        push_slot(0, 16'h0000, 4'h0, bus.lz_supp_i);
        rst_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (an_o === 4'hF && n < 200);
        chk({tag, " first low cyc"}, 32'(n), 32'(BLK + 1));
        e = sb.pop_front();
        chk({tag, " first an"},  32'(an_o),  32'(e.an));
        chk({tag, " first seg"}, 32'(seg_o), 32'(e.seg));
        chk({tag, " first dp"},  32'(dp_o),  32'(e.dp));
    endtask

    initial begin
        int n;
        int bad;
        rst_n         = 1'b0;
        bus.en_i      = 1'b1;
        bus.we_i      = 1'b0;
        bus.data_i    = '0;
        bus.dp_i      = '0;
        bus.lz_supp_i = 1'b0;

        // Reset from power-up
        reset_check("rst0");

        // Scan order and glyphs for 1A3F
        wr(16'h1A3F, 4'h0);
        wait_frame("scan");
        push_frame(16'h1A3F, 4'h0, 1'b0);
        for (int k = 0; k < N; k++) check_slot($sformatf("scan d%0d", k));

        // Frame period
        wait_frame("period a");
        n = 0;
        do begin tick(); n++; end while (frame_o !== 1'b1 && n < 400);
        chk("frame period", 32'(n), 32'(N * DIV));

        // Tear-free update: write 0000 while digit 2 is being scanned
        wait_frame("tear");
        push_slot(0, 16'h1A3F, 4'h0, 1'b0);
        push_slot(1, 16'h1A3F, 4'h0, 1'b0);
        check_slot("tear d0");
        check_slot("tear d1");
        wr(16'h0000, 4'h0);
        push_slot(2, 16'h1A3F, 4'h0, 1'b0);
        push_slot(3, 16'h1A3F, 4'h0, 1'b0);
        push_frame(16'h0000, 4'h0, 1'b0);
        check_slot("tear old d2");
        check_slot("tear old d3");
        for (int k = 0; k < N; k++) check_slot($sformatf("tear new d%0d", k));

        // Leading-zero suppression
        bus.lz_supp_i = 1'b1;
        wr(16'h0050, 4'h0);
        wait_frame("lz50");
        push_frame(16'h0050, 4'h0, 1'b1);
        for (int k = 0; k < N; k++) check_slot($sformatf("lz50 d%0d", k));
        wr(16'h0000, 4'h0);
        wait_frame("lz00");
        push_frame(16'h0000, 4'h0, 1'b1);
        for (int k = 0; k < N; k++) check_slot($sformatf("lz00 d%0d", k));
        bus.lz_supp_i = 1'b0;

        // Decimal point on digit 2 only
        wr(16'h1A3F, 4'b0100);
        wait_frame("dp");
        push_frame(16'h1A3F, 4'b0100, 1'b0);
        for (int k = 0; k < N; k++) check_slot($sformatf("dp d%0d", k));

        // Enable freeze in the middle of slot 1
        push_slot(0, 16'h1A3F, 4'b0100, 1'b0);
        check_slot("en d0");
        n = 0;
        while (an_o === 4'hF && n < 200) begin tick(); n++; end
        chk("en pre an",  32'(an_o),  32'(4'b1101));
        chk("en pre seg", 32'(seg_o), 32'h06);
        repeat (4) tick();
        bus.en_i = 1'b0;
        tick();
        chk("en dark an",    32'(an_o),    32'hF);
        chk("en dark seg",   32'(seg_o),   32'h7F);
        chk("en dark dp",    32'(dp_o),    32'd1);
        chk("en dark frame", 32'(frame_o), 32'd0);
        bad = 0;
        repeat (49) begin
            tick();
            if (an_o !== 4'hF || seg_o !== 7'h7F || dp_o !== 1'b1 || frame_o !== 1'b0) bad++;
        end
        chk("en dark hold", 32'(bad), 32'd0);
        bus.en_i = 1'b1;
        tick();
        chk("en resume an",  32'(an_o),  32'(4'b1101));
        chk("en resume seg", 32'(seg_o), 32'h06);
        n = 0;
        while (an_o === 4'b1101 && n < 200) begin n++; tick(); end
        chk("en resume len", 32'(n), 32'(LOW_LEN - 5));
        push_slot(2, 16'h1A3F, 4'b0100, 1'b0);
        push_slot(3, 16'h1A3F, 4'b0100, 1'b0);
        check_slot("en d2");
        check_slot("en d3");

        // Write coinciding with the wrap cycle
        n = 0;
        while (an_o !== 4'hF && n < 200) begin tick(); n++; end
        n = 0;
        while (an_o !== 4'b0111 && n < 400) begin tick(); n++; end
        repeat (DIV - BLK - 2) tick();
        wr(16'h00C5, 4'b0001);
        chk("wrap wr frame", 32'(frame_o), 32'd1);
        push_frame(16'h1A3F, 4'b0100, 1'b0);
        push_frame(16'h00C5, 4'b0001, 1'b0);
        for (int k = 0; k < N; k++) check_slot($sformatf("wrap old d%0d", k));
        for (int k = 0; k < N; k++) check_slot($sformatf("wrap new d%0d", k));

        // Reset in the middle of a scan clears value and scan position
        repeat (7) tick();
        reset_check("rst mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
